wx_matvec_engine: RTL and testbench
===================================

WX_MATVEC_ENGINE -- requirements
Module: wx_matvec_engine

Interface
REQ-001 SHALL have parameter ROWS, default 10, number of matrix rows (>=1).
REQ-002 SHALL have parameter COLS, default 10, number of matrix columns / vector length (>=1).
REQ-003 SHALL have parameter DATA_W, default 16, operand width (bf16).
REQ-004 SHALL have parameter ACC_W, default 32, product and accumulator width.
REQ-005 SHALL have parameter TIMEOUT, default 1024, maximum cycles spent waiting for mul_ready.
REQ-006 SHALL derive WA_W = max(1, ceil(log2(ROWS*COLS))) and XA_W = max(1, ceil(log2(COLS))).
REQ-007 SHALL use one clock and an asynchronous, active-low reset.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 start  in  1  begin a W*x run; sampled only in IDLE.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse on successful run completion.
REQ-013 w_addr  out  WA_W  W memory address = i*COLS + j.
REQ-014 w_rdata  in  DATA_W  W word; synchronous read, valid one cycle after w_addr.
REQ-015 x_addr  out  XA_W  x memory address = j.
REQ-016 x_rdata  in  DATA_W  x word; synchronous read, valid one cycle after x_addr.
REQ-017 mul_start  out  1  one-cycle multiplier launch pulse.
REQ-018 mul_a, mul_b  out  DATA_W each  operands (W element, x element).
REQ-019 mul_ready  in  1  multiplier result valid.
REQ-020 mul_out  in  ACC_W  multiplier result bits.
REQ-021 res_valid  out  1  row result available.
REQ-022 res_ready  in  1  downstream accepts row result.
REQ-023 res_row  out  ceil(log2(ROWS)) (min 1)  row index of res_data.
REQ-024 res_data  out  ACC_W  row accumulation.
REQ-025 cycle_count  out  32  busy cycles of current/last run.
REQ-026 err_timeout  out  1  sticky multiplier-timeout flag.

Function
REQ-027 SHALL implement states IDLE, FETCH, ISSUE, WAIT, ROW_OUT, DONE.
REQ-028 IDLE: start=1 -> FETCH with i=0, j=0, acc=0, cycle_count=0, err_timeout=0; start while busy SHALL be ignored.
REQ-029 FETCH: drive w_addr/x_addr for (i,j); -> ISSUE next cycle.
REQ-030 ISSUE: mul_start=1, mul_a=w_rdata, mul_b=x_rdata for exactly this cycle; -> WAIT; mul_a/mul_b SHALL hold until leaving WAIT.
REQ-031 WAIT: mul_ready sampled only here (not in ISSUE); on mul_ready=1, acc <= acc + mul_out modulo 2^ACC_W (unsigned bit-sum, no saturation); then j<COLS-1 -> j+1, FETCH; j=COLS-1 -> ROW_OUT.
REQ-032 ROW_OUT: res_valid=1, res_data=acc, res_row=i held stable until res_ready=1; on handshake: i<ROWS-1 -> i+1, j=0, acc=0, FETCH; i=ROWS-1 -> DONE.
REQ-033 DONE: done=1 for one cycle; -> IDLE.
REQ-034 cycle_count SHALL increment every cycle state is not IDLE, saturate at 2^32-1, and hold after return to IDLE.
REQ-035 WAIT timeout: if TIMEOUT consecutive WAIT cycles elapse without mul_ready, SHALL set err_timeout, return to IDLE, not pulse done, not assert res_valid.
REQ-036 Accumulator wrap-around SHALL be silent (no flag).
REQ-037 mul_ready outside WAIT SHALL be ignored.

Reset
REQ-038 rst_n=0 SHALL immediately force IDLE; busy, done, mul_start, res_valid, err_timeout = 0; w_addr, x_addr, mul_a, mul_b, res_row, res_data, cycle_count = 0.
REQ-039 Reset mid-run SHALL abandon the run; no done, no further res_valid; next start restarts at row 0.

Verification
REQ-040 ROWS=2, COLS=3, multiplier model ready one cycle at 3 cycles after mul_start, res_ready tied 1, mul_out=1 -> res_data 3 for rows 0 and 1, done one pulse, cycle_count=33.
REQ-041 Same config, res_ready low 4 cycles in row 0 ROW_OUT -> res_valid/res_data/res_row stable across stall, cycle_count=37.
REQ-042 ROWS=1, COLS=2, mul_out=0xFFFFFFFF then 0x00000002 -> res_data 0x00000001 (wrap), no error.
REQ-043 TIMEOUT=8, multiplier never ready -> err_timeout=1 after 8 WAIT cycles, busy=0, no done, no res_valid; next start clears err_timeout.
REQ-044 rst_n pulsed low during WAIT of row 1 -> all outputs 0 asynchronously; new start yields correct row 0 result.
REQ-045 start asserted during busy and mul_ready asserted during ISSUE -> both ignored, results identical to REQ-040.

Source files
------------

// File: rtl/wx_matvec_engine.sv
// Purpose : sequential W*x matrix-vector engine. Walks the matrix row-major,
//           launches one external multiply per element and accumulates per row.
// Latency : per element 2 + (multiplier wait) cycles, +1 per row for ROW_OUT, +1 DONE.
// Backpr. : each row result is held in ROW_OUT (res_valid) until res_ready; the
//           multiplier is waited on for at most TIMEOUT cycles before aborting.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start / busy / done        run control and status (done = 1-cycle pulse)
//   w_addr/w_rdata             W memory, synchronous read (i*COLS + j)
//   x_addr/x_rdata             x memory, synchronous read (j)
//   mul_start/mul_a/mul_b      multiplier launch and operands
//   mul_ready/mul_out          multiplier result
//   res_valid/res_ready        row result handshake, res_row/res_data payload
//   cycle_count                busy cycles of the current/last run (saturating)
//   err_timeout                sticky multiplier-timeout flag, cleared by start
module wx_matvec_engine #(
  parameter int ROWS    = 10,
  parameter int COLS    = 10,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 1024,
  localparam int WA_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
  localparam int XA_W   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RR_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [XA_W-1:0]   x_addr,
  input  logic [DATA_W-1:0] x_rdata,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_ready,
  input  logic [ACC_W-1:0]  mul_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RR_W-1:0]   res_row,
  output logic [ACC_W-1:0]  res_data,
  output logic [31:0]       cycle_count,
  output logic              err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_ROW_OUT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [RR_W-1:0]   i_q;
  logic [XA_W-1:0]   j_q;
  logic [WA_W-1:0]   w_addr_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic [31:0]       cycle_cnt_q;
  logic              err_q;

  logic last_col;
  logic last_row;
  logic wait_expired;

  assign last_col     = (j_q == XA_W'(COLS - 1));
  assign last_row     = (i_q == RR_W'(ROWS - 1));
  // wait_cnt_q counts completed WAIT cycles; this is the TIMEOUT-th one.
  assign wait_expired = (wait_cnt_q == TO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (mul_ready) begin
          state_d = last_col ? S_ROW_OUT : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_IDLE;
        end
      end
      S_ROW_OUT: if (res_ready) state_d = last_row ? S_DONE : S_FETCH;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state. The operands come straight from the memories
  // during ISSUE and from the captured copy afterwards, so they stay stable for
  // the whole WAIT even if the memory read data moves on.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mul_start = (state_q == S_ISSUE);
    res_valid = (state_q == S_ROW_OUT);
    mul_a     = (state_q == S_ISSUE) ? w_rdata : opa_q;
    mul_b     = (state_q == S_ISSUE) ? x_rdata : opb_q;
  end

  // Datapath: indices, addresses, accumulator, timeout and cycle counters.
  // w_addr is advanced incrementally; row-major layout makes the step from the
  // last column of row i to column 0 of row i+1 also a +1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q         <= '0;
      j_q         <= '0;
      w_addr_q    <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      wait_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q != S_IDLE && cycle_cnt_q != '1) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            i_q         <= '0;
            j_q         <= '0;
            w_addr_q    <= '0;
            acc_q       <= '0;
            cycle_cnt_q <= '0;
            err_q       <= 1'b0;
          end
        end
        S_ISSUE: begin
          opa_q      <= w_rdata;
          opb_q      <= x_rdata;
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          if (mul_ready) begin
            // Plain modular sum: wrap-around is intentional and unflagged.
            acc_q <= acc_q + mul_out;
            if (!last_col) begin
              j_q      <= j_q + XA_W'(1);
              w_addr_q <= w_addr_q + WA_W'(1);
            end
          end else if (wait_expired) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        S_ROW_OUT: begin
          if (res_ready && !last_row) begin
            i_q      <= i_q + RR_W'(1);
            j_q      <= '0;
            acc_q    <= '0;
            w_addr_q <= w_addr_q + WA_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addr      = w_addr_q;
  assign x_addr      = j_q;
  assign res_row     = i_q;
  assign res_data    = acc_q;
  assign cycle_count = cycle_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_wx_matvec_engine.sv
// Purpose : randomized self-checking bench for wx_matvec_engine (2x3, TIMEOUT=8).
// Latency : multiplier stub answers a programmable number of cycles after launch.
// Backpr. : res_ready stalls are injected per row from a queue.
module tb_wx_matvec_engine;
  localparam int ROWS    = 2;
  localparam int COLS    = 3;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int TIMEOUT = 8;
  localparam int WA_W    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int XA_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RR_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [WA_W-1:0]   w_addr;
  logic [DATA_W-1:0] w_rdata;
  logic [XA_W-1:0]   x_addr;
  logic [DATA_W-1:0] x_rdata;
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_ready;
  logic [ACC_W-1:0]  mul_out;
  logic              res_valid;
  logic              res_ready;
  logic [RR_W-1:0]   res_row;
  logic [ACC_W-1:0]  res_data;
  logic [31:0]       cycle_count;
  logic              err_timeout;

  wx_matvec_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .w_rdata(w_rdata), .x_addr(x_addr), .x_rdata(x_rdata),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
    .res_data(res_data), .cycle_count(cycle_count), .err_timeout(err_timeout)
  );

  // Memories and reference model
  logic [DATA_W-1:0] wmem [0:(1<<WA_W)-1];
  logic [DATA_W-1:0] xmem [0:(1<<XA_W)-1];
  logic [31:0]       exp_res [0:ROWS-1];
  logic [31:0]       obs_res [0:ROWS-1];

  // Stimulus / monitor state
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fixed_lat = 3;
  bit          never_ready = 0;
  bit          spur = 0;
  int          lat_sum, stall_sum, done_cnt, res_cnt, vld_seen, exp_row;
  bit          in_row;
  int          stall_left;
  int          stall_q[$];
  logic [31:0] first_data;
  logic [RR_W-1:0] first_row;
  bit          pend;
  int          pend_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Multiplier stub: product = {a, b} so operand order and fetch addresses
  // both show up in the row sums.
  function automatic void build_model();
    for (int i = 0; i < ROWS; i++) begin
      logic [31:0] acc;
      acc = 32'd0;
      for (int j = 0; j < COLS; j++) acc = acc + {wmem[i*COLS+j], xmem[j]};
      exp_res[i] = acc;
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Synchronous-read memories
  initial begin
    w_rdata = '0;
    x_rdata = '0;
    forever begin
      @(posedge clk);
      w_rdata = wmem[w_addr];
      x_rdata = xmem[x_addr];
    end
  end

  // Multiplier model
  initial begin
    mul_ready = 1'b0;
    mul_out   = '0;
    pend      = 1'b0;
    pend_cnt  = 0;
    forever begin
      @(negedge clk);
      mul_ready = 1'b0;
      mul_out   = $urandom;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            mul_ready = 1'b1;
            mul_out   = {mul_a, mul_b};
            pend      = 1'b0;
          end
        end
        if (mul_start) begin
          if (!never_ready) begin
            int lat;
            lat      = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 6);
            pend     = 1'b1;
            pend_cnt = lat;
            lat_sum += lat;
          end
          if (spur) begin
            mul_ready = 1'b1;
            mul_out   = $urandom;
          end
        end
      end
    end
  end

  // Result sink with per-row stalls, and done/valid monitor
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (res_valid && rst_n) begin
        vld_seen++;
        if (!in_row) begin
          in_row     = 1'b1;
          first_data = res_data;
          first_row  = res_row;
          stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
          stall_sum += stall_left;
        end
        if (stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
          check("res_data_stable", res_data, first_data);
          check("res_row_stable", 32'(res_row), 32'(first_row));
          check("res_row", 32'(res_row), 32'(exp_row));
          if (exp_row < ROWS) begin
            check("res_data", res_data, exp_res[exp_row]);
            obs_res[exp_row] = res_data;
          end
          exp_row++;
          res_cnt++;
          in_row = 1'b0;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "/busy"}, 32'(busy), 0);
    check({tag, "/done"}, 32'(done), 0);
    check({tag, "/mul_start"}, 32'(mul_start), 0);
    check({tag, "/res_valid"}, 32'(res_valid), 0);
    check({tag, "/err"}, 32'(err_timeout), 0);
    check({tag, "/w_addr"}, 32'(w_addr), 0);
    check({tag, "/x_addr"}, 32'(x_addr), 0);
    check({tag, "/mul_a"}, 32'(mul_a), 0);
    check({tag, "/mul_b"}, 32'(mul_b), 0);
    check({tag, "/res_row"}, 32'(res_row), 0);
    check({tag, "/res_data"}, res_data, 0);
    check({tag, "/cycle_count"}, cycle_count, 0);
  endtask

  task automatic launch();
    build_model();
    lat_sum   = 0;
    stall_sum = 0;
    done_cnt  = 0;
    res_cnt   = 0;
    vld_seen  = 0;
    exp_row   = 0;
    in_row    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_err_clear", 32'(err_timeout), 0);
  endtask

  task automatic wait_idle(input int budget, input bit noise);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      start = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      c++;
    end
    start = 1'b0;
    check("idle_reached", 32'(busy), 0);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/rows"}, res_cnt, ROWS);
    check({tag, "/cycle_count"}, cycle_count,
          32'(ROWS*COLS*2 + lat_sum + ROWS + stall_sum + 1));
    check({tag, "/err"}, 32'(err_timeout), 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < (1<<WA_W); k++) wmem[k] = 16'($urandom);
    for (int k = 0; k < (1<<XA_W); k++) xmem[k] = 16'($urandom);
  endtask

  task automatic fill_ones();
    for (int k = 0; k < (1<<WA_W); k++) wmem[k] = 16'h0000;
    for (int k = 0; k < (1<<XA_W); k++) xmem[k] = 16'h0001;
  endtask

  initial begin
    int c;
    start = 1'b0;
    rst_n = 1'b1;
    fill_ones();
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unit products, fixed latency 3: each row sums to 3, 33 busy cycles.
    fill_ones();
    fixed_lat = 3;
    launch();
    wait_idle(2000, 1'b0);
    end_checks("basic");
    check("basic/row0", obs_res[0], 32'd3);
    check("basic/row1", obs_res[1], 32'd3);
    check("basic/cycles33", cycle_count, 32'd33);
    repeat (3) @(negedge clk);
    check("basic/count_hold", cycle_count, 32'd33);

    // Four-cycle stall on row 0 result.
    stall_q.push_back(4);
    launch();
    wait_idle(2000, 1'b0);
    end_checks("stall");
    check("stall/cycles37", cycle_count, 32'd37);

    // Accumulator wrap: 0xFFFFFFFF + 0x2 + 0 -> 0x1, silently.
    fill_ones();
    for (int k = 0; k < (1<<XA_W); k++) xmem[k] = 16'h0000;
    wmem[0] = 16'hFFFF; xmem[0] = 16'hFFFF;
    xmem[1] = 16'h0002;
    launch();
    wait_idle(2000, 1'b0);
    end_checks("wrap");
    check("wrap/row0", obs_res[0], 32'h0000_0001);

    // Spurious start while busy and mul_ready during ISSUE are ignored.
    fill_ones();
    spur = 1'b1;
    launch();
    wait_idle(2000, 1'b1);
    end_checks("ignore");
    check("ignore/cycles33", cycle_count, 32'd33);
    check("ignore/row0", obs_res[0], 32'd3);
    spur = 1'b0;

    // Multiplier never answers: abort after exactly TIMEOUT WAIT cycles.
    never_ready = 1'b1;
    launch();
    c = 0;
    while (!mul_start && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("to/issue_seen", 32'(mul_start), 1);
    repeat (TIMEOUT) @(negedge clk);
    check("to/busy_last_wait", 32'(busy), 1);
    check("to/err_before", 32'(err_timeout), 0);
    @(negedge clk);
    check("to/err_set", 32'(err_timeout), 1);
    check("to/busy_low", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("to/no_done", done_cnt, 0);
    check("to/no_res_valid", vld_seen, 0);
    check("to/err_sticky", 32'(err_timeout), 1);
    never_ready = 1'b0;

    // Next run clears the error (checked in launch) and completes normally.
    fill_random();
    fixed_lat = 0;
    launch();
    wait_idle(2000, 1'b0);
    end_checks("after_to");

    // Asynchronous reset during WAIT of row 1 abandons the run.
    fill_random();
    fixed_lat = 3;
    launch();
    c = 0;
    while (!(res_cnt == 1 && mul_start) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("rst/row1_issue", 32'(res_row), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst/no_done", done_cnt, 0);
    check("rst/rows_before", res_cnt, 1);
    launch();
    wait_idle(2000, 1'b0);
    end_checks("rst_rerun");

    // Randomized runs: random data, latency, stalls, spurious events.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      fixed_lat = 0;
      spur      = 1'($urandom_range(0, 1));
      for (int k = 0; k < ROWS; k++) stall_q.push_back($urandom_range(0, 3));
      launch();
      wait_idle(2000, 1'($urandom_range(0, 1)));
      end_checks("rand");
      stall_q.delete();
    end
    spur = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
